pe_credit_node: RTL and testbench

Parametrised NoC processor element and successor to the fixed 4-credit PE. It injects self-generated, addressed packets into its router port under credit-based flow control with a configurable inter-packet gap. It sinks ejected flits, checks their destination and per-source sequence, and returns one credit per accepted flit. It also exposes counters and sticky error flags for system-level traffic tests.

---
 rtl/pe_noc_pkg.sv | 40 ++++
 rtl/pe_rx_checker.sv | 64 ++++++
 rtl/pe_credit_node.sv | 135 +++++++++++++
 tb/tb_pe_credit_node.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_noc_pkg.sv
// Shared definitions for the credit-based NoC processor element:
// field widths/offsets, injection FSM states and destination rotation.
package pe_noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_GAP   = 2'd2
    } inj_state_t;

    function automatic int id_width(input int num_nodes);
        return (num_nodes > 1) ? $clog2(num_nodes) : 1;
    endfunction

    function automatic int seq_width(input int data_w, input int num_nodes);
        return data_w - 2 * id_width(num_nodes);
    endfunction

    // Flit layout is {dest, src, seq}, MSB first; these give each field's LSB.
    localparam int SEQ_LSB = 0;

    function automatic int src_lsb(input int data_w, input int num_nodes);
        return seq_width(data_w, num_nodes);
    endfunction

    function automatic int dest_lsb(input int data_w, input int num_nodes);
        return data_w - id_width(num_nodes);
    endfunction

    // Cyclic destination walk that never addresses the sending node itself.
    function automatic int next_dest(input int cur, input int self_id, input int num_nodes);
        int nxt;
        nxt = (cur + 1) % num_nodes;
        if (nxt == self_id) begin
            nxt = (nxt + 1) % num_nodes;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pe_rx_checker.sv
// Ejection side of the PE: accepts every flit, returns one credit per flit,
// and checks destination and per-source sequence continuity.
module pe_rx_checker
    import pe_noc_pkg::*;
#(
    parameter int DATA_W    = 20,
    parameter int NUM_NODES = 16,
    parameter int NODE_ID   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic [15:0]       rx_count,
    output logic              misroute_err,
    output logic              seq_err
);

    localparam int ID_W     = id_width(NUM_NODES);
    localparam int SEQ_W    = seq_width(DATA_W, NUM_NODES);
    localparam int DEST_LSB = dest_lsb(DATA_W, NUM_NODES);
    localparam int SRC_LSB  = src_lsb(DATA_W, NUM_NODES);
    localparam logic [ID_W-1:0] SELF_ID = ID_W'(NODE_ID);

    logic [ID_W-1:0]  rx_dest;
    logic [ID_W-1:0]  rx_src;
    logic [SEQ_W-1:0] rx_seq;

    // Sized to the full src field so any src value indexes a real entry.
    logic [SEQ_W-1:0] exp_tab [2**ID_W];

    assign rx_dest = datain[DEST_LSB +: ID_W];
    assign rx_src  = datain[SRC_LSB +: ID_W];
    assign rx_seq  = datain[SEQ_LSB +: SEQ_W];

    // Stage boundary: flit accepted -> credit pulse, counters and flags registered
    always_ff @(posedge clk) begin
        if (rst) begin
            co           <= 1'b0;
            rx_count     <= '0;
            misroute_err <= 1'b0;
            seq_err      <= 1'b0;
            for (int i = 0; i < 2**ID_W; i++) begin
                exp_tab[i] <= '0;
            end
        end else begin
            co <= in_valid;
            if (in_valid) begin
                rx_count <= rx_count + 16'd1;
                if (rx_dest != SELF_ID) begin
                    misroute_err <= 1'b1;
                end else begin
                    if (rx_seq != exp_tab[rx_src]) begin
                        seq_err <= 1'b1;
                    end
                    // Always resynchronise so a single gap raises only one error.
                    exp_tab[rx_src] <= rx_seq + SEQ_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pe_credit_node.sv
// NoC processor element: credit-limited packet injector with configurable
// inter-packet gap, plus an ejection checker returning one credit per flit.
module pe_credit_node
    import pe_noc_pkg::*;
#(
    parameter int DATA_W    = 20,
    parameter int NUM_NODES = 16,
    parameter int NODE_ID   = 5,
    parameter int CREDITS   = 4,
    parameter int GAP       = 0
) (
    input  logic                             clk,
    input  logic                             RST,
    input  logic                             inj_en,
    input  logic [DATA_W-1:0]                datain,
    input  logic                             in_valid,
    input  logic                             ci,
    output logic [DATA_W-1:0]                dataout,
    output logic                             out_valid,
    output logic                             co,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
    output logic [15:0]                      tx_count,
    output logic [15:0]                      rx_count,
    output logic                             misroute_err,
    output logic                             seq_err,
    output logic                             credit_err
);

    localparam int ID_W  = id_width(NUM_NODES);
    localparam int SEQ_W = seq_width(DATA_W, NUM_NODES);
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [ID_W-1:0]  SELF_ID    = ID_W'(NODE_ID);
    localparam logic [ID_W-1:0]  FIRST_DEST = ID_W'((NODE_ID + 1) % NUM_NODES);
    localparam logic [CNT_W-1:0] CRED_MAX   = CNT_W'(CREDITS);

    inj_state_t       state;
    inj_state_t       state_nxt;
    logic             vld_p0;
    logic [ID_W-1:0]  tx_dest;
    logic [SEQ_W-1:0] tx_seq;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_last;

    assign gap_last = (int'(gap_cnt) == GAP - 1);

    // Send decision looks only at the registered credit count; a same-cycle
    // ci cannot unblock a send.
    always_comb begin
        state_nxt = state;
        vld_p0    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inj_en) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (!inj_en) begin
                    state_nxt = ST_IDLE;
                end else if (credit_cnt < CRED_MAX) begin
                    vld_p0 = 1'b1;
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_last) begin
                    state_nxt = inj_en ? ST_READY : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage boundary: send decision -> registered flit, credit and counters
    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= ST_IDLE;
            dataout    <= '0;
            out_valid  <= 1'b0;
            tx_dest    <= FIRST_DEST;
            tx_seq     <= '0;
            gap_cnt    <= '0;
            credit_cnt <= '0;
            tx_count   <= '0;
            credit_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= vld_p0;

            if (state == ST_GAP && !gap_last) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (vld_p0) begin
                dataout  <= {tx_dest, SELF_ID, tx_seq};
                tx_dest  <= ID_W'(next_dest(int'(tx_dest), NODE_ID, NUM_NODES));
                tx_seq   <= tx_seq + SEQ_W'(1);
                tx_count <= tx_count + 16'd1;
            end

            case ({vld_p0, ci})
                2'b10: credit_cnt <= credit_cnt + CNT_W'(1);
                2'b01: begin
                    if (credit_cnt == '0) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    pe_rx_checker #(
        .DATA_W    (DATA_W),
        .NUM_NODES (NUM_NODES),
        .NODE_ID   (NODE_ID)
    ) u_rx (
        .clk          (clk),
        .rst          (RST),
        .datain       (datain),
        .in_valid     (in_valid),
        .co           (co),
        .rx_count     (rx_count),
        .misroute_err (misroute_err),
        .seq_err      (seq_err)
    );

endmodule

// File: tb/tb_pe_credit_node.sv
// Directed bench for pe_credit_node: credit fill/return, dest rotation,
// receive checking, credit error, inter-packet gap and mid-stream reset.
module tb_pe_credit_node;

    localparam int DATA_W = 20;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              inj_en = 1'b0;
    logic [DATA_W-1:0] datain = '0;
    logic              in_valid = 1'b0;
    logic              ci = 1'b0;
    logic [DATA_W-1:0] dataout;
    logic              out_valid;
    logic              co;
    logic [CNT_W-1:0]  credit_cnt;
    logic [15:0]       tx_count;
    logic [15:0]       rx_count;
    logic              misroute_err;
    logic              seq_err;
    logic              credit_err;

    logic              inj_en_g = 1'b0;
    logic [DATA_W-1:0] datain_g = '0;
    logic              in_valid_g = 1'b0;
    logic              ci_g = 1'b0;
    logic [DATA_W-1:0] dataout_g;
    logic              out_valid_g;
    logic              co_g;
    logic [CNT_W-1:0]  credit_cnt_g;
    logic [15:0]       tx_count_g;
    logic [15:0]       rx_count_g;
    logic              misroute_err_g;
    logic              seq_err_g;
    logic              credit_err_g;

    pe_credit_node #(
        .DATA_W(20), .NUM_NODES(16), .NODE_ID(5), .CREDITS(4), .GAP(0)
    ) dut (
        .clk(clk), .RST(rst), .inj_en(inj_en), .datain(datain), .in_valid(in_valid),
        .ci(ci), .dataout(dataout), .out_valid(out_valid), .co(co),
        .credit_cnt(credit_cnt), .tx_count(tx_count), .rx_count(rx_count),
        .misroute_err(misroute_err), .seq_err(seq_err), .credit_err(credit_err)
    );

    pe_credit_node #(
        .DATA_W(20), .NUM_NODES(16), .NODE_ID(5), .CREDITS(4), .GAP(2)
    ) dut_g (
        .clk(clk), .RST(rst), .inj_en(inj_en_g), .datain(datain_g), .in_valid(in_valid_g),
        .ci(ci_g), .dataout(dataout_g), .out_valid(out_valid_g), .co(co_g),
        .credit_cnt(credit_cnt_g), .tx_count(tx_count_g), .rx_count(rx_count_g),
        .misroute_err(misroute_err_g), .seq_err(seq_err_g), .credit_err(credit_err_g)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DATA_W-1:0] flit;
        logic              mis;
        logic              seq;
    } rx_vec_t;

    rx_vec_t           rx_tab [7];
    logic [DATA_W-1:0] tx_fill [4];
    logic [DATA_W-1:0] tx_b2b [6];
    logic [DATA_W-1:0] got [20];
    int                cyc [8];
    int                nf;
    logic [DATA_W-1:0] expf;
    logic [DATA_W-1:0] first_g;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dataout"},    32'(dataout), 0);
        check({tag, "_out_valid"},  32'(out_valid), 0);
        check({tag, "_co"},         32'(co), 0);
        check({tag, "_credit_cnt"}, 32'(credit_cnt), 0);
        check({tag, "_tx_count"},   32'(tx_count), 0);
        check({tag, "_rx_count"},   32'(rx_count), 0);
        check({tag, "_misroute"},   32'(misroute_err), 0);
        check({tag, "_seq_err"},    32'(seq_err), 0);
        check({tag, "_credit_err"}, 32'(credit_err), 0);
    endtask

    function automatic int exp_dest(input int k);
        if (k < 10) return 6 + k;
        if (k < 15) return k - 10;
        return k - 9;
    endfunction

    initial begin
        tx_fill = '{20'h65000, 20'h75001, 20'h85002, 20'h95003};
        tx_b2b  = '{20'hB5005, 20'hC5006, 20'hD5007, 20'hE5008, 20'hF5009, 20'h0500A};
        rx_tab[0] = '{flit: 20'h53000, mis: 1'b0, seq: 1'b0};
        rx_tab[1] = '{flit: 20'h53001, mis: 1'b0, seq: 1'b0};
        rx_tab[2] = '{flit: 20'h5A000, mis: 1'b0, seq: 1'b0};
        rx_tab[3] = '{flit: 20'h73000, mis: 1'b1, seq: 1'b0};
        rx_tab[4] = '{flit: 20'h53002, mis: 1'b1, seq: 1'b0};
        rx_tab[5] = '{flit: 20'h53004, mis: 1'b1, seq: 1'b1};
        rx_tab[6] = '{flit: 20'h53005, mis: 1'b1, seq: 1'b1};

        // Reset state
        rst = 1'b1;
        step();
        check_zero("rst");
        check("rst_g_out_valid",  32'(out_valid_g), 0);
        check("rst_g_credit_cnt", 32'(credit_cnt_g), 0);
        check("rst_g_dataout",    32'(dataout_g), 0);
        check("rst_g_flags",      32'({co_g, misroute_err_g, seq_err_g, credit_err_g}), 0);
        check("rst_g_counts",     32'({tx_count_g, rx_count_g}), 0);
        rst = 1'b0;

        // Credit fill: four back-to-back flits, then stall
        inj_en = 1'b1;
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) begin
                if (nf < 8) begin
                    got[nf] = dataout;
                    cyc[nf] = i;
                end
                nf++;
            end
        end
        check("fill_count", nf, 4);
        for (int k = 0; k < 4 && k < nf; k++) begin
            check($sformatf("fill_flit%0d", k), 32'(got[k]), 32'(tx_fill[k]));
            check($sformatf("fill_cycle%0d", k), cyc[k], cyc[0] + k);
        end
        check("fill_credit_cnt", 32'(credit_cnt), 4);
        check("fill_out_valid", 32'(out_valid), 0);
        check("fill_tx_count", 32'(tx_count), 4);

        // Single credit return, then send one cycle later
        ci = 1'b1;
        step();
        ci = 1'b0;
        check("ret_credit_cnt", 32'(credit_cnt), 3);
        check("ret_no_send_yet", 32'(out_valid), 0);
        step();
        check("ret_out_valid", 32'(out_valid), 1);
        check("ret_flit", 32'(dataout), 32'h000A5004);
        check("ret_credit_full", 32'(credit_cnt), 4);

        // Back-to-back credit returns keep flits flowing
        ci = 1'b1;
        step();
        check("b2b_first_cnt", 32'(credit_cnt), 3);
        check("b2b_first_valid", 32'(out_valid), 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("b2b_valid%0d", k), 32'(out_valid), 1);
            check($sformatf("b2b_flit%0d", k), 32'(dataout), 32'(tx_b2b[k]));
            check($sformatf("b2b_cnt%0d", k), 32'(credit_cnt), 3);
        end
        check("b2b_credit_err", 32'(credit_err), 0);

        // Reset mid-stream
        rst = 1'b1;
        step();
        check_zero("midrst");
        rst = 1'b0;
        ci = 1'b0;
        nf = 0;
        for (int i = 0; i < 10 && nf == 0; i++) begin
            step();
            if (out_valid) begin
                got[0] = dataout;
                nf = 1;
            end
        end
        check("midrst_found", nf, 1);
        if (nf == 1) check("midrst_first_flit", 32'(got[0]), 32'h00065000);

        // Dest rotation with a credit returned after each flit
        inj_en = 1'b0;
        do_reset();
        inj_en = 1'b1;
        nf = 0;
        for (int i = 0; i < 60 && nf < 17; i++) begin
            step();
            ci = out_valid;
            if (out_valid) begin
                got[nf] = dataout;
                nf++;
            end
        end
        ci = 1'b0;
        inj_en = 1'b0;
        check("rot_count", nf, 17);
        for (int k = 0; k < nf && k < 17; k++) begin
            expf = {4'(exp_dest(k)), 4'h5, 12'(k)};
            check($sformatf("rot_flit%0d", k), 32'(got[k]), 32'(expf));
            if (got[k][19:16] == 4'h5) check($sformatf("rot_self%0d", k), 1, 0);
        end
        if (nf >= 16) check("rot_flit16", 32'(got[15]), 32'h0006500F);
        check("rot_credit_err", 32'(credit_err), 0);

        // Receive checking, back-to-back flits
        do_reset();
        for (int i = 0; i < 7; i++) begin
            datain = rx_tab[i].flit;
            in_valid = 1'b1;
            step();
            check($sformatf("rx%0d_co", i), 32'(co), 1);
            check($sformatf("rx%0d_rx_count", i), 32'(rx_count), i + 1);
            check($sformatf("rx%0d_misroute", i), 32'(misroute_err), 32'(rx_tab[i].mis));
            check($sformatf("rx%0d_seq_err", i), 32'(seq_err), 32'(rx_tab[i].seq));
        end
        in_valid = 1'b0;
        step();
        check("rx_co_idle", 32'(co), 0);
        check("rx_count_hold", 32'(rx_count), 7);

        // Credit error on ci with nothing outstanding
        do_reset();
        ci = 1'b1;
        step();
        ci = 1'b0;
        check("cerr_flag", 32'(credit_err), 1);
        check("cerr_cnt", 32'(credit_cnt), 0);
        step();
        check("cerr_sticky", 32'(credit_err), 1);

        // Inter-packet gap of 2 cycles
        do_reset();
        inj_en_g = 1'b1;
        nf = 0;
        first_g = '0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid_g) begin
                if (nf == 0) first_g = dataout_g;
                if (nf < 8) cyc[nf] = i;
                nf++;
            end
        end
        inj_en_g = 1'b0;
        check("gap_count", nf, 4);
        check("gap_first_flit", 32'(first_g), 32'h00065000);
        for (int k = 1; k < nf && k < 8; k++) begin
            check($sformatf("gap_spacing%0d", k), cyc[k] - cyc[k-1], 3);
        end
        check("gap_credit_cnt", 32'(credit_cnt_g), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
